// File: rtl/alu_seq_writeback.sv
// Execute/write-back stage feeding the 2D register file: single-cycle ALU ops plus an
// iterative shift-add multiply, with a one-cycle one-hot write strobe and registered flags.
module alu_seq_writeback #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [2:0]            opcode,
   input  logic [1:0]            src_a,
   input  logic [1:0]            src_b,
   input  logic [1:0]            dst,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [DATA_WIDTH-1:0] r0,
   input  logic [DATA_WIDTH-1:0] r1,
   input  logic [DATA_WIDTH-1:0] r2,
   input  logic [DATA_WIDTH-1:0] r3,
   output logic [DATA_WIDTH-1:0] ALUBus,
   output logic [3:0]            regEnable,
   output logic                  flag_zero,
   output logic                  flag_carry,
   output logic                  busy
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDI = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_CMP = 3'd7;

   typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

   state_t                    state_reg, state_next;
   logic [2:0]                opcode_reg;
   logic [1:0]                dst_reg;
   logic [DATA_WIDTH-1:0]     result_reg;
   logic                      carry_reg;
   logic                      flag_zero_reg;
   logic                      flag_carry_reg;
   logic [2*DATA_WIDTH-1:0]   mcand_reg;
   logic [DATA_WIDTH-1:0]     mplier_reg;
   logic [2*DATA_WIDTH-1:0]   prod_reg;
   logic [CW-1:0]             cnt_reg;

   logic [DATA_WIDTH-1:0]     rf_view [4];
   logic [DATA_WIDTH-1:0]     operand_a, operand_b;
   logic [DATA_WIDTH:0]       sum_ext, diff_ext;
   logic [DATA_WIDTH-1:0]     alu_result;
   logic                      alu_carry;
   logic [2*DATA_WIDTH-1:0]   prod_next;
   logic                      accept;
   logic                      mul_last;
   logic                      wr_en;

   assign rf_view[0] = r0;
   assign rf_view[1] = r1;
   assign rf_view[2] = r2;
   assign rf_view[3] = r3;
   assign operand_a  = rf_view[src_a];
   assign operand_b  = rf_view[src_b];

   // Borrow falls out as the top bit of the zero-extended difference.
   assign sum_ext  = {1'b0, operand_a} + {1'b0, operand_b};
   assign diff_ext = {1'b0, operand_a} - {1'b0, operand_b};

   always_comb begin
      alu_result = '0;
      alu_carry  = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_result = sum_ext[DATA_WIDTH-1:0];
            alu_carry  = sum_ext[DATA_WIDTH];
         end
         OP_SUB, OP_CMP: begin
            alu_result = diff_ext[DATA_WIDTH-1:0];
            alu_carry  = diff_ext[DATA_WIDTH];
         end
         OP_AND:  alu_result = operand_a & operand_b;
         OP_OR:   alu_result = operand_a | operand_b;
         OP_XOR:  alu_result = operand_a ^ operand_b;
         OP_LDI:  alu_result = imm;
         default: alu_result = '0;
      endcase
   end

   assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
   assign mul_last  = (cnt_reg == CW'(DATA_WIDTH - 1));
   assign accept    = (state_reg == IDLE) && op_valid;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (op_valid) state_next = (opcode == OP_MUL) ? MUL : WB;
         MUL:     if (mul_last) state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         opcode_reg     <= '0;
         dst_reg        <= '0;
         result_reg     <= '0;
         carry_reg      <= 1'b0;
         flag_zero_reg  <= 1'b0;
         flag_carry_reg <= 1'b0;
         mcand_reg      <= '0;
         mplier_reg     <= '0;
         prod_reg       <= '0;
         cnt_reg        <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            opcode_reg <= opcode;
            dst_reg    <= dst;
            if (opcode == OP_MUL) begin
               mcand_reg  <= {{DATA_WIDTH{1'b0}}, operand_a};
               mplier_reg <= operand_b;
               prod_reg   <= '0;
               cnt_reg    <= '0;
            end else begin
               result_reg <= alu_result;
               carry_reg  <= alu_carry;
            end
         end
         if (state_reg == MUL) begin
            prod_reg   <= prod_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (mul_last) begin
               result_reg <= prod_next[DATA_WIDTH-1:0];
               carry_reg  <= |prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
            end
         end
         if (state_reg == WB) begin
            flag_zero_reg  <= (result_reg == '0);
            flag_carry_reg <= carry_reg;
         end
      end
   end

   // CMP only updates flags, so it never strobes the register file.
   assign wr_en = (state_reg == WB) && (opcode_reg != OP_CMP);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wr_dec
         assign regEnable[gi] = wr_en && (dst_reg == 2'(gi));
      end
   endgenerate

   assign ALUBus     = result_reg;
   assign flag_zero  = flag_zero_reg;
   assign flag_carry = flag_carry_reg;
   assign op_ready   = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);

endmodule
